// File: rtl/coin_pkg.sv
// ---------------------------------------------------------------------------
// coin_pkg
// Shared types and defaults for the coin input conditioner.
//   coin_code_t     : 1-bit pending-coin code stored in the FIFO (N = 0, D = 1)
//   issue_state_t   : issue FSM encoding (IDLE / ISSUE / GAP)
//   DEFAULT_*       : default parameter values for the conditioner
//   sat_inc8        : saturating 8-bit increment used by the drop counter
// ---------------------------------------------------------------------------
package coin_pkg;

  typedef enum logic {
    COIN_N = 1'b0,
    COIN_D = 1'b1
  } coin_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } issue_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_FIFO_DEPTH      = 4;
  localparam int DEFAULT_GAP_CYCLES      = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// ---------------------------------------------------------------------------
// coin_debounce
// One sensor channel: 2-flop synchronizer, debounce counter and a registered
// one-cycle pulse on each accepted 0->1 transition of the debounced level.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   raw_i   in   asynchronous, possibly bouncing sensor line
//   rise_o  out  one-cycle pulse per debounced rising edge
// ---------------------------------------------------------------------------
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       level_q;
  logic       level_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       rise_q;
  logic       rise_d;

  // Debounce: a differing synchronized level must persist DEBOUNCE_CYCLES
  // consecutive cycles (counter 0..DEBOUNCE_CYCLES-1) before it is accepted.
  always_comb begin
    level_d = level_q;
    cnt_d   = 8'd0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = 8'd0;
    end
    // Event is registered together with the level so it is exactly one cycle.
    rise_d = level_d & ~level_q;
  end

  // Synchronizer, debounce and event registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= 8'd0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// ---------------------------------------------------------------------------
// coin_input_conditioner
// Turns bouncy asynchronous nickel/dime sensor lines into clean single-cycle
// inN/inD pulses for the vend FSM. Coins are queued in a small FIFO and issued
// one at a time, never while vend_busy is high, with idle spacing after each.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   coin_n_raw   in   nickel sensor (async, may bounce)
//   coin_d_raw   in   dime sensor (async, may bounce)
//   vend_busy    in   downstream FSM is in its 15-cent state
//   inN / inD    out  one-cycle coin pulses to the vend FSM
//   coin_reject  out  one-cycle pulse when a coin is dropped on a full FIFO
//   drop_count   out  saturating count of dropped coins
//   fifo_level   out  number of pending coins
// ---------------------------------------------------------------------------
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH,
  parameter int GAP_CYCLES      = DEFAULT_GAP_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin_n_raw,
  input  logic                          coin_d_raw,
  input  logic                          vend_busy,
  output logic                          inN,
  output logic                          inD,
  output logic                          coin_reject,
  output logic [7:0]                    drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // Outputs are registered, so the IDLE cycle that pops the next coin is
  // itself an idle output cycle: the GAP state only covers the remaining
  // GAP_CYCLES-1 cycles.
  localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;
  localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  logic ev_n;
  logic ev_d;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_n (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (coin_n_raw),
    .rise_o (ev_n)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (coin_d_raw),
    .rise_o (ev_d)
  );

  logic [FIFO_DEPTH-1:0] fifo_mem_q, fifo_mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      count_q, count_d;
  logic                  pend_d_q, pend_d_d;
  logic                  reject_q, reject_d;
  logic [7:0]            drop_q, drop_d;
  issue_state_t          state_q, state_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  in_n_q, in_n_d;
  logic                  in_d_q, in_d_d;

  logic                  push_req_s;
  coin_code_t            push_code_s;
  logic                  full_s;
  logic                  push_ok_s;
  logic                  pop_s;
  coin_code_t            head_s;

  // Push arbitration, FIFO bookkeeping and the issue FSM.
  always_comb begin
    push_req_s  = 1'b0;
    push_code_s = COIN_N;
    pend_d_d    = pend_d_q;
    // A deferred dime goes first; a channel cannot produce a new event one
    // cycle after its previous one, so nothing competes with it here.
    if (pend_d_q) begin
      push_req_s  = 1'b1;
      push_code_s = COIN_D;
      pend_d_d    = 1'b0;
    end else if (ev_n) begin
      push_req_s  = 1'b1;
      push_code_s = COIN_N;
      pend_d_d    = ev_d;
    end else if (ev_d) begin
      push_req_s  = 1'b1;
      push_code_s = COIN_D;
    end else begin
      push_req_s  = 1'b0;
    end

    full_s    = (count_q == LVL_W'(FIFO_DEPTH));
    push_ok_s = push_req_s & ~full_s;
    reject_d  = push_req_s & full_s;
    drop_d    = reject_d ? sat_inc8(drop_q) : drop_q;

    head_s  = coin_code_t'(fifo_mem_q[rd_ptr_q]);
    pop_s   = 1'b0;
    state_d = state_q;
    gap_d   = gap_q;
    in_n_d  = 1'b0;
    in_d_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !vend_busy) begin
          pop_s   = 1'b1;
          in_n_d  = (head_s == COIN_N);
          in_d_d  = (head_s == COIN_D);
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        gap_d   = '0;
        state_d = (GAP_CYCLES > 1) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    if (push_ok_s) begin
      fifo_mem_d[wr_ptr_q] = push_code_s;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards queued coins and any active pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pend_d_q   <= 1'b0;
      reject_q   <= 1'b0;
      drop_q     <= 8'd0;
      state_q    <= IDLE;
      gap_q      <= '0;
      in_n_q     <= 1'b0;
      in_d_q     <= 1'b0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pend_d_q   <= pend_d_d;
      reject_q   <= reject_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      in_n_q     <= in_n_d;
      in_d_q     <= in_d_d;
    end
  end

  assign inN         = in_n_q;
  assign inD         = in_d_q;
  assign coin_reject = reject_q;
  assign drop_count  = drop_q;
  assign fifo_level  = count_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_coin_input_conditioner
// Directed bench for coin_input_conditioner with default parameters
// (DEBOUNCE_CYCLES = 4, FIFO_DEPTH = 4, GAP_CYCLES = 2). Inputs change 1 ns
// after a rising edge; "edge k" below counts rising edges from that change.
// ---------------------------------------------------------------------------
module tb_coin_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_n_raw;
  logic       coin_d_raw;
  logic       vend_busy;
  logic       in_n;
  logic       in_d;
  logic       coin_reject;
  logic [7:0] drop_count;
  logic [2:0] fifo_level;

  int errors = 0;
  int checks = 0;

  int n_total = 0;
  int d_total = 0;
  int rej_total = 0;
  int viol_total = 0;
  logic prev_pulse = 1'b0;

  int n0, d0, r0;

  coin_input_conditioner dut (
    .clk         (clk),
    .rst         (rst),
    .coin_n_raw  (coin_n_raw),
    .coin_d_raw  (coin_d_raw),
    .vend_busy   (vend_busy),
    .inN         (in_n),
    .inD         (in_d),
    .coin_reject (coin_reject),
    .drop_count  (drop_count),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  // Pulse counters and spacing monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (in_n) n_total <= n_total + 1;
    if (in_d) d_total <= d_total + 1;
    if (coin_reject) rej_total <= rej_total + 1;
    if ((in_n && in_d) || ((in_n || in_d) && prev_pulse)) viol_total <= viol_total + 1;
    prev_pulse <= in_n | in_d;
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; coin_n_raw = 1'b0; coin_d_raw = 1'b0; vend_busy = 1'b0;
    step(3);
    check_eq("rst_inN", int'(in_n), 0);
    check_eq("rst_inD", int'(in_d), 0);
    check_eq("rst_reject", int'(coin_reject), 0);
    check_eq("rst_drop", int'(drop_count), 0);
    check_eq("rst_level", int'(fifo_level), 0);
    rst = 1'b0;
    step(2);

    // Clean nickel: pulse in the cycle after edge 8.
    n0 = n_total; d0 = d_total;
    coin_n_raw = 1'b1;
    step(7);
    check_eq("t1_inN_e7", int'(in_n), 0);
    check_eq("t1_level_e7", int'(fifo_level), 1);
    step(1);
    check_eq("t1_inN_e8", int'(in_n), 1);
    check_eq("t1_inD_e8", int'(in_d), 0);
    check_eq("t1_level_e8", int'(fifo_level), 0);
    step(1);
    check_eq("t1_inN_e9", int'(in_n), 0);
    step(11);
    coin_n_raw = 1'b0;
    step(15);
    check_eq("t1_n_pulses", n_total - n0, 1);
    check_eq("t1_d_pulses", d_total - d0, 0);

    // Bouncy dime then a solid hold: exactly one inD.
    n0 = n_total; d0 = d_total;
    coin_d_raw = 1'b1; step(1);
    coin_d_raw = 1'b0; step(1);
    coin_d_raw = 1'b1; step(1);
    coin_d_raw = 1'b0; step(1);
    coin_d_raw = 1'b1; step(10);
    coin_d_raw = 1'b0; step(15);
    check_eq("t2_d_pulses", d_total - d0, 1);
    check_eq("t2_n_pulses", n_total - n0, 0);

    // 3-cycle glitches never pass.
    n0 = n_total; d0 = d_total;
    coin_n_raw = 1'b1; step(3);
    coin_n_raw = 1'b0; step(15);
    coin_d_raw = 1'b1; step(3);
    coin_d_raw = 1'b0; step(15);
    check_eq("t2_glitch_n", n_total - n0, 0);
    check_eq("t2_glitch_d", d_total - d0, 0);
    check_eq("t2_level", int'(fifo_level), 0);

    // Simultaneous rises: inN at edge 8, two low cycles, inD at edge 11.
    coin_n_raw = 1'b1; coin_d_raw = 1'b1;
    step(8);
    check_eq("t3_inN_e8", int'(in_n), 1);
    check_eq("t3_inD_e8", int'(in_d), 0);
    check_eq("t3_level_e8", int'(fifo_level), 1);
    step(1);
    check_eq("t3_any_e9", int'(in_n | in_d), 0);
    step(1);
    check_eq("t3_any_e10", int'(in_n | in_d), 0);
    step(1);
    check_eq("t3_inD_e11", int'(in_d), 1);
    check_eq("t3_inN_e11", int'(in_n), 0);
    step(1);
    check_eq("t3_inD_e12", int'(in_d), 0);
    check_eq("t3_level_e12", int'(fifo_level), 0);
    coin_n_raw = 1'b0; coin_d_raw = 1'b0;
    step(15);

    // Hold-off: queue N, D, N under vend_busy, then release.
    vend_busy = 1'b1;
    n0 = n_total; d0 = d_total;
    coin_n_raw = 1'b1; coin_d_raw = 1'b1; step(8);
    coin_n_raw = 1'b0; coin_d_raw = 1'b0; step(10);
    coin_n_raw = 1'b1; step(8);
    coin_n_raw = 1'b0; step(12);
    check_eq("t4_level_busy", int'(fifo_level), 3);
    check_eq("t4_pulses_busy", (n_total - n0) + (d_total - d0), 0);
    vend_busy = 1'b0;
    step(1);
    check_eq("t4_first_inN", int'(in_n), 1);
    check_eq("t4_level_1", int'(fifo_level), 2);
    step(3);
    check_eq("t4_second_inD", int'(in_d), 1);
    step(3);
    check_eq("t4_third_inN", int'(in_n), 1);
    check_eq("t4_level_0", int'(fifo_level), 0);
    step(5);

    // Overflow: 6 nickels into a 4-deep FIFO while busy.
    vend_busy = 1'b1;
    n0 = n_total; r0 = rej_total;
    for (int i = 0; i < 6; i++) begin
      coin_n_raw = 1'b1; step(7);
      coin_n_raw = 1'b0; step(7);
    end
    step(5);
    check_eq("t5_level_full", int'(fifo_level), 4);
    check_eq("t5_rejects", rej_total - r0, 2);
    check_eq("t5_drop_count", int'(drop_count), 2);
    vend_busy = 1'b0;
    step(20);
    check_eq("t5_n_pulses", n_total - n0, 4);
    check_eq("t5_level_empty", int'(fifo_level), 0);

    // Reset while ISSUE is active with 3 coins still queued.
    vend_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      coin_n_raw = 1'b1; step(7);
      coin_n_raw = 1'b0; step(7);
    end
    step(5);
    check_eq("t6_level_pre", int'(fifo_level), 4);
    vend_busy = 1'b0;
    step(1);
    check_eq("t6_inN_issue", int'(in_n), 1);
    check_eq("t6_level_issue", int'(fifo_level), 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("t6_inN_after_rst", int'(in_n), 0);
    check_eq("t6_inD_after_rst", int'(in_d), 0);
    check_eq("t6_level_after_rst", int'(fifo_level), 0);
    check_eq("t6_drop_after_rst", int'(drop_count), 0);
    n0 = n_total; d0 = d_total;
    step(20);
    check_eq("t6_stale_pulses", (n_total - n0) + (d_total - d0), 0);

    check_eq("spacing_violations", viol_total, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
- Front-end stage that feeds the coin-counting vend FSM.
- Converts raw, bouncy, asynchronous coin-sensor lines (nickel, dime) into clean single-cycle inN/inD pulses.
- Buffers coins in a small FIFO and meters them out one at a time, never during a vend cycle, so no coin is lost while the downstream FSM sits in its 15-cent state.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required before a level change is accepted. Legal range 2..255.
- FIFO_DEPTH, 4: pending-coin buffer entries. Power of 2, minimum 2.
- GAP_CYCLES, 2: minimum idle cycles after each issued pulse. Minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- coin_n_raw  in  1  nickel sensor, asynchronous, may bounce
- coin_d_raw  in  1  dime sensor, asynchronous, may bounce
- vend_busy  in  1  downstream vend output; high means the FSM is in its 15-cent state
- inN  out  1  one-cycle nickel pulse to the vend FSM
- inD  out  1  one-cycle dime pulse to the vend FSM
- coin_reject  out  1  one-cycle pulse: a coin was dropped because the FIFO was full
- drop_count  out  8  saturating count of dropped coins
- fifo_level  out  clog2(FIFO_DEPTH)+1  current number of pending coins

Behaviour:
- All state is registered on the rising edge of clk. rst is sampled synchronously and has priority over everything.
- Reset values:
  - inN, inD, coin_reject = 0; drop_count = 0; fifo_level = 0.
  - Synchronizers and debounced levels = 0; debounce counters = 0; pending-dime flag = 0.
  - FSM = IDLE.
- Synchronizer: each raw line passes through 2 flip-flops before any other logic uses it.
- Debounce, per channel:
  - If the synchronized level equals the debounced level, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes the debounced level.
- Coin event: a registered one-cycle pulse on each 0->1 transition of a debounced level. Falling transitions generate nothing.
- A raw line held high across reset release produces exactly one event after the debounce completes.
- FIFO push:
  - A nickel event pushes code N. A dime event pushes code D.
  - If both events occur in the same cycle, N is pushed that cycle and D is held in the pending-dime flag and pushed the next cycle. This ordering is fixed.
- FIFO full at push:
  - The entry is discarded and coin_reject pulses high for that cycle.
  - drop_count increments, saturating at 255.
  - FIFO contents are unchanged.
- Issue FSM:
  - IDLE: if the FIFO is non-empty and vend_busy = 0, pop the head and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: exactly one of inN/inD is high for this single cycle, matching the popped code. Then go to GAP.
  - GAP: outputs low for GAP_CYCLES cycles, then IDLE.
- Pulse spacing:
  - inN and inD are never high together, and never high in consecutive cycles.
  - No pulse is issued while vend_busy = 1.
- Simultaneous push and pop in one cycle is legal; fifo_level is unchanged in that case.
- Pop-on-empty cannot occur.
- Latency: with the FIFO empty, FSM in IDLE and vend_busy = 0, a clean raw rising edge first sampled at edge 1 produces the output pulse in the cycle following edge DEBOUNCE_CYCLES+4.
- Reset mid-operation:
  - Pending coins, the pending-dime flag and any in-flight debounce are discarded.
  - Any active pulse drops low in the cycle after the reset edge.

Decomposition:
- Shared package coin_pkg:
  - coin_code_t, 1 bit: N = 0, D = 1.
  - Default values for DEBOUNCE_CYCLES, FIFO_DEPTH and GAP_CYCLES.
  - FSM state encoding IDLE/ISSUE/GAP.
- Sub-module coin_debounce: synchronizer, debounce counter and rise-event register for one channel, instantiated twice.
- FIFO and issue FSM live in the top module.

Test Plan:
- Clean nickel, DEBOUNCE_CYCLES = 4: coin_n_raw high for 20 cycles from edge 1 -> inN high for exactly one cycle following edge 8; inD never asserts; fifo_level returns to 0.
- Bouncy dime: coin_d_raw toggles 1,0,1,0 each cycle, then holds high 10 cycles -> exactly one inD pulse; a 3-cycle-only high glitch on either line -> no pulse.
- Simultaneous nickel and dime rises on the same edge -> inN pulse, then GAP_CYCLES = 2 low cycles, then inD pulse; order is fixed.
- Hold-off: 3 coins queued with vend_busy forced high for 10 cycles -> zero pulses during busy; pulses resume the first IDLE cycle after vend_busy falls, in push order.
- Overflow, FIFO_DEPTH = 4, vend_busy held high: 6 nickel events -> fifo_level = 4, coin_reject pulses twice, drop_count = 2; after release, exactly 4 inN pulses.
- Reset mid-operation: rst for 1 cycle with 3 coins queued and FSM in ISSUE -> next cycle inN = inD = 0, fifo_level = 0, drop_count = 0; no stale pulse afterwards.
